// File: rtl/line_fill_engine_if.sv
// Refill port bundle: cache-side fill request/beat stream plus the Sysbus
// master signals, with the engine on the master modport.
interface line_fill_engine_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8
);
  localparam int IDX_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic                      fill_req;
  logic [63:0]               fill_addr;
  logic                      has_bus;
  logic                      oassert_bus;
  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;
  logic                      fill_busy;
  logic [63:0]               fill_line_addr;
  logic                      fill_beat_valid;
  logic [IDX_WIDTH-1:0]      fill_beat_idx;
  logic [BUS_DATA_WIDTH-1:0] fill_beat_data;
  logic                      fill_done;

  modport master (
    input  fill_req, fill_addr, has_bus, bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output oassert_bus, bus_reqcyc, bus_req, bus_reqtag, bus_respack, fill_busy,
           fill_line_addr, fill_beat_valid, fill_beat_idx, fill_beat_data, fill_done
  );

  modport slave (
    output fill_req, fill_addr, has_bus, bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  oassert_bus, bus_reqcyc, bus_req, bus_reqtag, bus_respack, fill_busy,
           fill_line_addr, fill_beat_valid, fill_beat_idx, fill_beat_data, fill_done
  );
endinterface

// File: rtl/line_fill_engine.sv
// Cache line refill master: wins the bus, issues one line read and streams the
// returned beats to the cache data array, then pulses fill_done.
module line_fill_engine #(
  parameter int                       BUS_DATA_WIDTH = 64,
  parameter int                       BUS_TAG_WIDTH  = 13,
  parameter int                       BEATS          = 8,
  parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG       = 13'h1100
) (
  input logic                clk,
  input logic                reset,
  line_fill_engine_if.master lf
);
  localparam int                   IDX_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_BEAT = IDX_WIDTH'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    REQ  = 3'd2,
    RESP = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                    state_r;
  logic [IDX_WIDTH-1:0]      count_r;
  logic                      oassert_bus_r;
  logic                      bus_reqcyc_r;
  logic [BUS_DATA_WIDTH-1:0] bus_req_r;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag_r;
  logic                      fill_busy_r;
  logic [63:0]               fill_line_addr_r;
  logic                      fill_beat_valid_r;
  logic [IDX_WIDTH-1:0]      fill_beat_idx_r;
  logic [BUS_DATA_WIDTH-1:0] fill_beat_data_r;
  logic                      fill_done_r;
  logic                      bus_respack_s;
  logic                      unused_s;

  // Response tag and the byte offset within the line carry no information here.
  assign unused_s = ^{lf.bus_resptag, lf.fill_addr[5:0]};

  // Beats are acknowledged combinationally, and only while collecting the line.
  always_comb begin
    bus_respack_s = 1'b0;
    if (state_r == RESP) begin
      bus_respack_s = lf.bus_respcyc;
    end else begin
      bus_respack_s = 1'b0;
    end
  end

  // Refill sequencer with registered bus and cache-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r           <= IDLE;
      count_r           <= '0;
      oassert_bus_r     <= 1'b0;
      bus_reqcyc_r      <= 1'b0;
      bus_req_r         <= '0;
      bus_reqtag_r      <= '0;
      fill_busy_r       <= 1'b0;
      fill_line_addr_r  <= 64'd0;
      fill_beat_valid_r <= 1'b0;
      fill_beat_idx_r   <= '0;
      fill_beat_data_r  <= '0;
      fill_done_r       <= 1'b0;
    end else begin
      fill_beat_valid_r <= 1'b0;
      fill_done_r       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (lf.fill_req) begin
            fill_line_addr_r <= {lf.fill_addr[63:6], 6'b000000};
            oassert_bus_r    <= 1'b1;
            fill_busy_r      <= 1'b1;
            state_r          <= ARB;
          end
        end
        ARB: begin
          if (lf.has_bus) begin
            bus_reqcyc_r <= 1'b1;
            bus_req_r    <= BUS_DATA_WIDTH'(fill_line_addr_r);
            bus_reqtag_r <= READ_TAG;
            state_r      <= REQ;
          end
        end
        REQ: begin
          if (lf.bus_reqack) begin
            bus_reqcyc_r <= 1'b0;
            bus_req_r    <= '0;
            bus_reqtag_r <= '0;
            state_r      <= RESP;
          end
        end
        RESP: begin
          // Grant loss is not checked here: the arbiter holds it while oassert_bus is high.
          if (lf.bus_respcyc) begin
            fill_beat_data_r  <= lf.bus_resp;
            fill_beat_idx_r   <= count_r;
            fill_beat_valid_r <= 1'b1;
            if (count_r == LAST_BEAT) begin
              count_r       <= '0;
              fill_done_r   <= 1'b1;
              oassert_bus_r <= 1'b0;
              state_r       <= DONE;
            end else begin
              count_r <= count_r + IDX_WIDTH'(1);
            end
          end
        end
        DONE: begin
          fill_busy_r <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          count_r       <= '0;
          oassert_bus_r <= 1'b0;
          bus_reqcyc_r  <= 1'b0;
          bus_req_r     <= '0;
          bus_reqtag_r  <= '0;
          fill_busy_r   <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

  assign lf.oassert_bus     = oassert_bus_r;
  assign lf.bus_reqcyc      = bus_reqcyc_r;
  assign lf.bus_req         = bus_req_r;
  assign lf.bus_reqtag      = bus_reqtag_r;
  assign lf.bus_respack     = bus_respack_s;
  assign lf.fill_busy       = fill_busy_r;
  assign lf.fill_line_addr  = fill_line_addr_r;
  assign lf.fill_beat_valid = fill_beat_valid_r;
  assign lf.fill_beat_idx   = fill_beat_idx_r;
  assign lf.fill_beat_data  = fill_beat_data_r;
  assign lf.fill_done       = fill_done_r;
endmodule

// File: tb/tb_line_fill_engine.sv
// Self-checking bench for line_fill_engine: scenario tasks drive fills and
// compare the delivered line against an expected beat list.
module tb_line_fill_engine;
  localparam int DW = 64;
  localparam int TW = 13;
  localparam int NB = 8;
  localparam logic [TW-1:0] EXP_TAG = 13'h1100;

  logic clk;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  line_fill_engine_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(NB)) lf ();

  line_fill_engine #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(NB), .READ_TAG(EXP_TAG)) dut (
    .clk  (clk),
    .reset(reset),
    .lf   (lf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed cache-side strobes, in arrival order
  logic [2:0]  sidx_q[$];
  logic [63:0] sdata_q[$];
  int          done_cnt;
  int          gap_pat[11] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1};
  logic [63:0] beat_val[NB];

  always @(negedge clk) begin
    if (lf.fill_beat_valid === 1'b1) begin
      sidx_q.push_back(lf.fill_beat_idx);
      sdata_q.push_back(lf.fill_beat_data);
    end
    if (lf.fill_done === 1'b1) done_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One complete fill; entered and left just after a falling edge.
  task automatic drive_fill(input logic [63:0] addr, input int grant_delay, input int ack_delay,
                            input int mode, input bit hold_req, input bit poke_req,
                            input bit drop_grant, input bit a0_data);
    logic [63:0] exp_line;
    int sent, cyc, v;
    bit bad;
    exp_line = {addr[63:6], 6'b000000};
    for (int k = 0; k < NB; k++) beat_val[k] = a0_data ? (64'hA0 + 64'(k)) : {$urandom, $urandom};
    sidx_q.delete();
    sdata_q.delete();
    done_cnt = 0;
    lf.fill_req  = 1'b1;
    lf.fill_addr = addr;
    lf.has_bus   = (grant_delay == 0);
    @(negedge clk);
    if (!hold_req) lf.fill_req = 1'b0;
    total_cnt++;
    if (lf.oassert_bus !== 1'b1 || lf.fill_busy !== 1'b1)
      $display("FAIL accept: oassert=%0b busy=%0b want 1 1", lf.oassert_bus, lf.fill_busy);
    else pass_cnt++;
    total_cnt++;
    if (lf.fill_line_addr !== exp_line)
      $display("FAIL line_addr: got %h want %h", lf.fill_line_addr, exp_line);
    else pass_cnt++;
    for (int i = 0; i < grant_delay; i++) begin
      total_cnt++;
      if (lf.bus_reqcyc !== 1'b0 || lf.oassert_bus !== 1'b1 || lf.fill_busy !== 1'b1)
        $display("FAIL wait_grant: reqcyc=%0b oassert=%0b busy=%0b want 0 1 1",
                 lf.bus_reqcyc, lf.oassert_bus, lf.fill_busy);
      else pass_cnt++;
      @(negedge clk);
    end
    lf.has_bus = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (lf.bus_reqcyc !== 1'b1 || lf.bus_req !== exp_line || lf.bus_reqtag !== EXP_TAG)
      $display("FAIL request: reqcyc=%0b req=%h tag=%h want 1 %h %h",
               lf.bus_reqcyc, lf.bus_req, lf.bus_reqtag, exp_line, EXP_TAG);
    else pass_cnt++;
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      total_cnt++;
      if (lf.bus_reqcyc !== 1'b1 || lf.bus_req !== exp_line || lf.bus_reqtag !== EXP_TAG)
        $display("FAIL req_hold: reqcyc=%0b req=%h tag=%h want 1 %h %h",
                 lf.bus_reqcyc, lf.bus_req, lf.bus_reqtag, exp_line, EXP_TAG);
      else pass_cnt++;
    end
    lf.bus_reqack = 1'b1;
    @(negedge clk);
    lf.bus_reqack = 1'b0;
    total_cnt++;
    if (lf.bus_reqcyc !== 1'b0 || lf.bus_req !== 64'd0 || lf.bus_reqtag !== 13'd0)
      $display("FAIL req_clear: reqcyc=%0b req=%h tag=%h want 0 0 0",
               lf.bus_reqcyc, lf.bus_req, lf.bus_reqtag);
    else pass_cnt++;
    sent = 0;
    cyc  = 0;
    while (sent < NB && cyc < 200) begin
      case (mode)
        0:       v = 1;
        1:       v = (cyc < 11) ? gap_pat[cyc] : 1;
        default: v = ($urandom_range(0, 2) != 0) ? 1 : 0;
      endcase
      lf.bus_respcyc = (v != 0);
      lf.bus_resp    = (v != 0) ? beat_val[sent] : {$urandom, $urandom};
      if (drop_grant && cyc == 1) lf.has_bus = 1'b0;
      if (poke_req && cyc == 2) begin
        lf.fill_req  = 1'b1;
        lf.fill_addr = addr ^ 64'h0000_0000_0004_0000;
      end else if (poke_req && cyc == 3) begin
        lf.fill_req = 1'b0;
      end
      #1;
      total_cnt++;
      if (lf.bus_respack !== (v != 0))
        $display("FAIL respack: cyc %0d got %0b want %0b", cyc, lf.bus_respack, (v != 0));
      else pass_cnt++;
      @(negedge clk);
      if (v != 0) sent++;
      cyc++;
    end
    total_cnt++;
    if (sent != NB) $display("FAIL beat_budget: sent %0d want %0d", sent, NB);
    else pass_cnt++;
    lf.bus_respcyc = 1'b1;
    #1;
    total_cnt++;
    if (lf.fill_done !== 1'b1 || lf.fill_beat_valid !== 1'b1 || lf.fill_beat_idx !== 3'd7 ||
        lf.oassert_bus !== 1'b0 || lf.fill_busy !== 1'b1 || lf.bus_respack !== 1'b0)
      $display("FAIL done_cycle: done=%0b valid=%0b idx=%0d oassert=%0b busy=%0b respack=%0b want 1 1 7 0 1 0",
               lf.fill_done, lf.fill_beat_valid, lf.fill_beat_idx, lf.oassert_bus,
               lf.fill_busy, lf.bus_respack);
    else pass_cnt++;
    total_cnt++;
    if (lf.fill_line_addr !== exp_line)
      $display("FAIL line_addr_kept: got %h want %h", lf.fill_line_addr, exp_line);
    else pass_cnt++;
    @(negedge clk);
    lf.bus_respcyc = 1'b0;
    total_cnt++;
    if (lf.fill_busy !== 1'b0 || lf.fill_done !== 1'b0 || lf.bus_reqcyc !== 1'b0)
      $display("FAIL idle_return: busy=%0b done=%0b reqcyc=%0b want 0 0 0",
               lf.fill_busy, lf.fill_done, lf.bus_reqcyc);
    else pass_cnt++;
    #2;
    bad = (sidx_q.size() != NB);
    for (int k = 0; k < sidx_q.size() && k < NB; k++)
      if (sidx_q[k] !== 3'(k) || sdata_q[k] !== beat_val[k]) bad = 1'b1;
    total_cnt++;
    if (bad)
      $display("FAIL line_data: got %0d strobes (first idx %0d) want %0d in order 0..7",
               sidx_q.size(), (sidx_q.size() > 0) ? int'(sidx_q[0]) : -1, NB);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt != 1) $display("FAIL done_count: got %0d want 1", done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    lf.fill_req = 1'b1; lf.fill_addr = 64'hFFFF_FFFF_FFFF_FFFF; lf.has_bus = 1'b1;
    lf.bus_reqack = 1'b0; lf.bus_respcyc = 1'b0; lf.bus_resp = '0; lf.bus_resptag = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({lf.oassert_bus, lf.bus_reqcyc, lf.bus_req, lf.bus_reqtag, lf.fill_busy, lf.fill_line_addr,
         lf.fill_beat_valid, lf.fill_beat_idx, lf.fill_beat_data, lf.fill_done} !== '0)
      $display("FAIL reset_outputs: busy=%0b reqcyc=%0b line=%h want all 0",
               lf.fill_busy, lf.bus_reqcyc, lf.fill_line_addr);
    else pass_cnt++;
    lf.fill_req = 1'b0;
    reset = 1'b0;
    lf.bus_respcyc = 1'b1;
    #1;
    total_cnt++;
    if (lf.bus_respack !== 1'b0) $display("FAIL reset_respack: got %0b want 0", lf.bus_respack);
    else pass_cnt++;
    @(negedge clk);
    lf.bus_respcyc = 1'b0;
  endtask

  task automatic test_basic();
    drive_fill(64'h0000_0000_0001_0038, 0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_delayed_grant();
    drive_fill(64'h0000_1234_5678_9AFF, 5, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_gapped();
    drive_fill(64'h8000_0000_0000_0040, 0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_inputs();
    drive_fill(64'h0000_0000_00AB_CDC7, 1, 2, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    sidx_q.delete();
    sdata_q.delete();
    for (int i = 0; i < 4; i++) begin
      lf.bus_respcyc = (i % 2 == 0);
      lf.bus_resp    = {$urandom, $urandom};
      #1;
      total_cnt++;
      if (lf.bus_respack !== 1'b0) $display("FAIL idle_respack: got %0b want 0", lf.bus_respack);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (lf.bus_reqcyc !== 1'b0 || lf.fill_busy !== 1'b0 || lf.oassert_bus !== 1'b0)
        $display("FAIL idle_quiet: reqcyc=%0b busy=%0b oassert=%0b want 0 0 0",
                 lf.bus_reqcyc, lf.fill_busy, lf.oassert_bus);
      else pass_cnt++;
    end
    lf.bus_respcyc = 1'b0;
    #2;
    total_cnt++;
    if (sidx_q.size() != 0) $display("FAIL idle_strobes: got %0d want 0", sidx_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_fill();
    done_cnt = 0;
    lf.fill_req = 1'b1; lf.fill_addr = 64'h0000_0000_0002_0000; lf.has_bus = 1'b1;
    @(negedge clk);
    lf.fill_req = 1'b0;
    @(negedge clk);
    lf.bus_reqack = 1'b1;
    @(negedge clk);
    lf.bus_reqack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      lf.bus_respcyc = 1'b1;
      lf.bus_resp    = {$urandom, $urandom};
      @(negedge clk);
    end
    lf.bus_respcyc = 1'b0;
    total_cnt++;
    if (lf.fill_beat_valid !== 1'b1 || lf.fill_beat_idx !== 3'd3)
      $display("FAIL pre_reset_beat: valid=%0b idx=%0d want 1 3", lf.fill_beat_valid, lf.fill_beat_idx);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total_cnt++;
    if ({lf.oassert_bus, lf.bus_reqcyc, lf.bus_req, lf.bus_reqtag, lf.fill_busy, lf.fill_line_addr,
         lf.fill_beat_valid, lf.fill_beat_idx, lf.fill_beat_data, lf.fill_done, lf.bus_respack} !== '0)
      $display("FAIL mid_reset_outputs: busy=%0b oassert=%0b valid=%0b done=%0b want all 0",
               lf.fill_busy, lf.oassert_bus, lf.fill_beat_valid, lf.fill_done);
    else pass_cnt++;
    #2;
    total_cnt++;
    if (done_cnt != 0) $display("FAIL mid_reset_done: got %0d want 0", done_cnt);
    else pass_cnt++;
    drive_fill(64'h0000_0000_0003_0010, 0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive_fill(64'h0000_0000_1000_0008, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_fill(64'h0000_0000_2000_0030, 0, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    lf.fill_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      drive_fill({$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 4), 2,
                 1'b0, 1'b0, ($urandom_range(0, 1) == 1), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delayed_grant();
    test_gapped();
    test_ignored_inputs();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
